// File: rtl/seg7_pkg.sv
// seg7_pkg: segment-off constant, active-low hex digit codes and the hex_to_seg7 lookup
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam seg_t HEX_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic seg_t hex_to_seg7(input logic [3:0] nibble);
    return HEX_CODES[nibble];
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: user-side bus (en, load, value, dp, blank_lz in; frame_start, digit, data out)
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic en;
  logic load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] dp;
  logic blank_lz;
  logic frame_start;
  logic [NUM_DIGITS-1:0] digit;
  logic [7:0] data;
  modport master (output en, load, value, dp, blank_lz, input frame_start, digit, data);
  modport slave (input en, load, value, dp, blank_lz, output frame_start, digit, data);
endinterface

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational nibble_i -> active-low seg_o (g..a)
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);
  assign seg_o = hex_to_seg7(nibble_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit seven-segment scanner (clk, rst, bus slave: load/value/dp/blank_lz/en in, digit/data/frame_start out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] pend_val_q, pend_val_d, shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d, digit_q, digit_d, nz;
  logic pend_lz_q, pend_lz_d, shd_lz_q, shd_lz_d, pend_valid_q, pend_valid_d;
  logic wrap_q, frame_start_q, slot_end, frame_end, take, supp, lit;
  logic [7:0] data_q, data_d;
  logic [3:0] nib;
  seg_t seg;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    assign nz[g] = |shd_val_q[4*g +: 4] | shd_dp_q[g];
  end
  seg7_hex_decoder u_dec (.nibble_i(nib), .seg_o(seg));
  always_comb begin
    slot_end = cnt_q == CW'(SLOT_CYCLES - 1);
    frame_end = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = frame_end ? '0 : slot_end ? idx_q + 1'b1 : idx_q;
    pend_val_d = bus.load ? bus.value : pend_val_q;
    pend_dp_d = bus.load ? bus.dp : pend_dp_q;
    pend_lz_d = bus.load ? bus.blank_lz : pend_lz_q;
    pend_valid_d = !frame_end && (bus.load || pend_valid_q);
    // pend_*_d already carries a same-cycle load, so a boundary load bypasses straight into the shadow
    take = frame_end && (bus.load || pend_valid_q);
    shd_val_d = take ? pend_val_d : shd_val_q;
    shd_dp_d = take ? pend_dp_d : shd_dp_q;
    shd_lz_d = take ? pend_lz_d : shd_lz_q;
    nib = shd_val_q[idx_q*4 +: 4];
    supp = shd_lz_q && idx_q != '0 && (nz >> idx_q) == '0;
    lit = bus.en && cnt_q >= CW'(BLANK_CYCLES) && !supp;
    digit_d = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    data_d = lit ? {~shd_dp_q[idx_q], seg} : SEG_OFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      pend_val_q <= '0;
      pend_dp_q <= '0;
      pend_lz_q <= 1'b0;
      pend_valid_q <= 1'b0;
      shd_val_q <= '0;
      shd_dp_q <= '0;
      shd_lz_q <= 1'b0;
      wrap_q <= 1'b0;
      frame_start_q <= 1'b0;
      digit_q <= '1;
      data_q <= SEG_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q <= pend_dp_d;
      pend_lz_q <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      shd_val_q <= shd_val_d;
      shd_dp_q <= shd_dp_d;
      shd_lz_q <= shd_lz_d;
      // wrap_q marks counters sitting at cnt=0/idx=0 after a real frame wrap (never after reset)
      wrap_q <= frame_end;
      frame_start_q <= wrap_q;
      digit_q <= digit_d;
      data_q <= data_d;
    end
  end
  assign bus.digit = digit_q;
  assign bus.data = data_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed stimulus with a cycle-stamped scoreboard for seg7_scan_driver
module tb_seg7_scan_driver;
  typedef struct {
    int cyc;
    logic [3:0] digit;
    logic [7:0] data;
    logic fs;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t e;
  exp_t left;
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();
  seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
  task automatic expect_at(input int n, input logic [3:0] d, input logic [7:0] s);
    exp_t x;
    x.cyc = n;
    x.digit = d;
    x.data = s;
    x.fs = n > 1 && (n - 1) % 32 == 0;
    q.push_back(x);
  endtask
  task automatic wait_neg(input int n);
    while (cyc != n) @(negedge clk);
  endtask
  task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] d, input logic b);
    wait_neg(n);
    bus.load = 1'b1;
    bus.value = v;
    bus.dp = d;
    bus.blank_lz = b;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL chk@%0d: not sampled, run already at cycle %0d", e.cyc, cyc);
      end else if ({bus.digit, bus.data, bus.frame_start} !== {e.digit, e.data, e.fs}) begin
        n_bad++;
        $display("FAIL chk@%0d: got digit=%h data=%h frame_start=%b, expected digit=%h data=%h frame_start=%b",
                 e.cyc, bus.digit, bus.data, bus.frame_start, e.digit, e.data, e.fs);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d checks pending", q.size());
    $fatal(1);
  end
  initial begin
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.value = '0;
    bus.dp = '0;
    bus.blank_lz = 1'b0;
    expect_at(0, 4'hF, 8'hFF);
    expect_at(1, 4'hF, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      expect_at(8*i + 2, 4'hF, 8'hFF);
      expect_at(8*i + 3, ~(4'b0001 << i), 8'hC0);
      expect_at(8*i + 8, ~(4'b0001 << i), 8'hC0);
    end
    expect_at(33, 4'hF, 8'hFF);
    expect_at(60, 4'h7, 8'hC0);
    expect_at(64, 4'h7, 8'hC0);
    expect_at(65, 4'hF, 8'hFF);
    expect_at(67, 4'hE, 8'h8E);
    expect_at(75, 4'hD, 8'h88);
    expect_at(83, 4'hB, 8'h24);
    expect_at(91, 4'h7, 8'hF9);
    expect_at(97, 4'hF, 8'hFF);
    expect_at(128, 4'h7, 8'hF9);
    expect_at(129, 4'hF, 8'hFF);
    expect_at(131, 4'hE, 8'h92);
    expect_at(139, 4'hF, 8'hFF);
    expect_at(147, 4'hF, 8'hFF);
    expect_at(155, 4'hF, 8'hFF);
    expect_at(160, 4'hF, 8'hFF);
    expect_at(161, 4'hF, 8'hFF);
    expect_at(163, 4'hE, 8'hC0);
    expect_at(171, 4'hF, 8'hFF);
    expect_at(192, 4'hF, 8'hFF);
    expect_at(193, 4'hF, 8'hFF);
    expect_at(195, 4'hE, 8'hB0);
    expect_at(203, 4'hD, 8'hB0);
    expect_at(219, 4'h7, 8'hB0);
    expect_at(230, 4'hE, 8'hB0);
    expect_at(231, 4'hF, 8'hFF);
    expect_at(235, 4'hF, 8'hFF);
    expect_at(245, 4'hF, 8'hFF);
    expect_at(250, 4'hF, 8'hFF);
    expect_at(251, 4'h7, 8'hB0);
    expect_at(257, 4'hF, 8'hFF);
    expect_at(260, 4'hE, 8'hB0);
    expect_at(263, 4'hE, 8'hB0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_load(44, 16'h12AF, 4'b0100, 1'b0);
    do_load(100, 16'h0005, 4'b0000, 1'b1);
    do_load(140, 16'h0000, 4'b0000, 1'b1);
    do_load(170, 16'h1111, 4'b0000, 1'b0);
    do_load(180, 16'h2222, 4'b0000, 1'b0);
    do_load(191, 16'h3333, 4'b0000, 1'b0);
    wait_neg(230);
    bus.en = 1'b0;
    wait_neg(250);
    bus.en = 1'b1;
    wait_neg(263);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expect_at(0, 4'hF, 8'hFF);
    expect_at(1, 4'hF, 8'hFF);
    expect_at(2, 4'hF, 8'hFF);
    expect_at(3, 4'hE, 8'hC0);
    expect_at(11, 4'hD, 8'hC0);
    expect_at(33, 4'hF, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    while (q.size() != 0) begin
      left = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL chk@%0d: never reached, run stopped at cycle %0d", left.cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It replaces the single-digit, static switch-to-segment decoder. The block accepts a packed hex value, per-digit decimal points and a load strobe. It scans the digits at a parametrised rate with an anti-ghosting blank interval and optional leading-zero suppression. It sits between user logic and the board's `digit`/`data` pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `SLOT_CYCLES`, 50000: clock cycles each digit is selected per frame; must be ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all digits off (anti-ghosting); 0 is legal.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  display enable; 0 forces all outputs off; the scan continues.
- `load`  in  1  one-cycle strobe; captures `value`, `dp` and `blank_lz` into the pending register.
- `value`  in  4·NUM_DIGITS  hex nibbles; nibble i is shown on digit i (digit 0 is least significant).
- `dp`  in  NUM_DIGITS  decimal-point request per digit, active-high.
- `blank_lz`  in  1  enables leading-zero suppression.
- `frame_start`  out  1  one-cycle pulse when a new frame begins and the shadow register updates.
- `digit`  out  NUM_DIGITS  digit select, active-low; bit i enables digit i.
- `data`  out  8  segment outputs, active-low; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.

## Operation
- State:
  - prescaler `cnt` counts 0..SLOT_CYCLES-1.
  - digit index `idx` counts 0..NUM_DIGITS-1.
  - pending register plus `pend_valid` flag.
  - shadow register, which is the source for the display.
- Scan:
  - `cnt` increments every cycle.
  - At `cnt`=SLOT_CYCLES-1, `cnt` returns to 0 and `idx` advances.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Frame boundary is the transition `cnt`=SLOT_CYCLES-1 with `idx`=NUM_DIGITS-1. At that transition:
  - if `pend_valid`, shadow ← pending and `pend_valid` clears;
  - `frame_start` pulses on the cycle when `cnt`=0 and `idx`=0.
- Load:
  - `load` sets `pend_valid` and overwrites the pending register.
  - With multiple loads in one frame, the last one wins.
  - A load on the same cycle as the frame boundary is taken at that boundary; the bypass path goes directly into the shadow register.
  - The shadow register never changes mid-frame, so a frame never tears.
- Output selection per cycle:
  - `en`=0, or `cnt` < BLANK_CYCLES: `digit` = all 1s, `data` = 8'hFF.
  - Digit `idx` suppressed: `digit` = all 1s, `data` = 8'hFF. A digit is suppressed when `blank_lz`=1, `idx`>0, and all shadow nibbles from `idx` up to NUM_DIGITS-1 are 0 with their dp bits 0. Digit 0 is never suppressed.
  - Otherwise: `digit` has only bit `idx` low, and `data` = {~dp[idx], hex code of nibble `idx`}.
- Hex codes (data[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset state: `digit` all 1s, `data`=8'hFF, `frame_start`=0, `cnt`=0, `idx`=0, shadow=0, pending=0, `pend_valid`=0, `blank_lz` shadow=0.
- Assertion of `rst` mid-scan blanks the outputs immediately, without waiting for `clk`.
- `digit`, `data` and `frame_start` are registered. Each is computed from the `cnt`/`idx`/shadow values present before the edge, so outputs lag the counters by exactly one cycle.
- Slot length is SLOT_CYCLES. Each slot has BLANK_CYCLES off, then SLOT_CYCLES-BLANK_CYCLES lit. Frame length is NUM_DIGITS·SLOT_CYCLES.
- Load-to-display latency:
  - minimum 2 cycles (load on the boundary cycle);
  - maximum NUM_DIGITS·SLOT_CYCLES+1 cycles.
- Deassertion of `en` takes effect on the next output register update (1 cycle).
- First `frame_start` after reset: the pulse fires on the first wrap of the frame boundary, which is NUM_DIGITS·SLOT_CYCLES cycles after reset release, registered one cycle later. No pulse is generated at reset release itself.

## Structure
- Package `seg7_pkg`:
  - `SEG_OFF` = 8'hFF constant;
  - function `hex_to_seg7(nibble)` returning 7 active-low bits;
  - 16-entry code constants.
- Sub-module `seg7_hex_decoder`: combinational wrapper around `hex_to_seg7`, instantiated once on the muxed nibble.
- Top level contains the prescaler, index counter, pending/shadow registers, leading-zero logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
- Reset release, `en`=1, no load: per 8-cycle slot, 2 cycles off then digit i low with `data`=8'hC0 ("0"), for i=0..3. `frame_start` pulses every 32 cycles.
- Load `value`=16'h12AF, `dp`=4'b0100 mid-frame: the current frame is unchanged. The next frame shows:
  - digit0 `data`=8'h8E;
  - digit1 `data`=8'h88;
  - digit2 `data`=8'h24 (dp on);
  - digit3 `data`=8'hF9.
- `blank_lz`=1, `value`=16'h0005: digits 3..1 off for their whole slots, digit0 `data`=8'h92. With `value`=0, digit0 shows 8'hC0.
- Two loads in one frame (16'h1111, then 16'h2222), plus a third load on the boundary cycle (16'h3333): the next frame shows all digits "3" (8'hB0).
- `rst` asserted mid-slot between edges: `digit`=4'hF and `data`=8'hFF immediately. After release, the scan restarts from digit0 `cnt`=0 and the display shows 0.
- `en`=0 for 20 cycles: all outputs off. `frame_start` cadence is unchanged, and the scan position resumes as if `en` had stayed high.
